// File: rtl/div_iter32.sv
// rtl/div_iter32.sv - iterative 32-bit signed divider, one quotient bit per cycle
module balanced_or32 (
    input  logic [31:0] x,
    output logic        y
);
    logic [15:0] l1;
    logic [7:0]  l2;
    logic [3:0]  l3;
    logic [1:0]  l4;

    assign l1 = x[31:16] | x[15:0];
    assign l2 = l1[15:8] | l1[7:0];
    assign l3 = l2[7:4]  | l2[3:0];
    assign l4 = l3[3:2]  | l3[1:0];
    assign y  = l4[1]    | l4[0];
endmodule

module div_iter32 (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] q, d;
    logic [32:0] r;
    logic [4:0]  cnt;
    logic        neg, bz;

    logic        b_nz;
    logic [31:0] abs_a, abs_b;
    logic [32:0] r_sh, r_sub, r_nx;
    logic [31:0] q_nx;
    logic        ge;
    logic [31:0] result_nxt;

    balanced_or32 u_bzd (.x(data_operandB), .y(b_nz));

    // Unsigned negate keeps |0x80000000| = 0x80000000.
    assign abs_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign abs_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

    // A bit shifted out of R[32] would always exceed D, so it forces a subtract.
    assign r_sh  = {r[31:0], q[31]};
    assign ge    = r[32] | (r_sh >= {1'b0, d});
    assign r_sub = r_sh - {1'b0, d};
    assign r_nx  = ge ? r_sub : r_sh;
    assign q_nx  = {q[30:0], ge};

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ctrl_DIV) begin
            state_nxt = b_nz ? RUN : DONE;
        end else begin
            case (state)
                RUN:     state_nxt = (cnt == 5'd31) ? DONE : RUN;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        result_nxt = 32'd0;
        if (!bz) result_nxt = neg ? (~q + 32'd1) : q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q              <= 32'd0;
            d              <= 32'd0;
            r              <= 33'd0;
            cnt            <= 5'd0;
            neg            <= 1'b0;
            bz             <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_DIV) begin
                q              <= abs_a;
                d              <= abs_b;
                r              <= 33'd0;
                cnt            <= 5'd0;
                neg            <= data_operandA[31] ^ data_operandB[31];
                bz             <= ~b_nz;
                data_exception <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        r   <= r_nx;
                        q   <= q_nx;
                        cnt <= cnt + 5'd1;
                    end
                    DONE: begin
                        data_result    <= result_nxt;
                        data_exception <= bz;
                        data_resultRDY <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_iter32.sv
// tb/tb_div_iter32.sv - directed checks for div_iter32
module tb_div_iter32;
    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int tests = 0;
    int fails = 0;

    div_iter32 dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Leaves the bench at the falling edge right after the start edge E0.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (data_resultRDY !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic check_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input logic exc, input int lat);
        int n;
        start_op(a, b);
        check({tag, " rdy_clr"}, {31'd0, data_resultRDY}, 32'd0);
        check({tag, " exc_clr"}, {31'd0, data_exception}, 32'd0);
        wait_rdy(n);
        check({tag, " latency"}, n, lat);
        check({tag, " result"}, data_result, exp);
        check({tag, " exc"}, {31'd0, data_exception}, {31'd0, exc});
        @(negedge clock);
        check({tag, " rdy_low"}, {31'd0, data_resultRDY}, 32'd0);
        check({tag, " hold"}, data_result, exp);
    endtask

    initial begin
        int seen;
        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (2) @(negedge clock);
        check("reset result", data_result, 32'd0);
        check("reset exc", {31'd0, data_exception}, 32'd0);
        check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b0;

        check_div("100/7",    32'd100,        32'd7,          32'd14,         1'b0, 33);
        check_div("-100/7",   32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   1'b0, 33);
        check_div("7/-2",     32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0, 33);
        check_div("5/0",      32'd5,          32'd0,          32'd0,          1'b1, 1);
        check_div("9/3",      32'd9,          32'd3,          32'd3,          1'b0, 33);
        check_div("min/-1",   32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0, 33);
        check_div("min/1",    32'h80000000,   32'd1,          32'h80000000,   1'b0, 33);
        check_div("3/10",     32'd3,          32'd10,         32'd0,          1'b0, 33);

        // Abort: restart with 81/9 on E10 of a 100/7 run.
        seen = 0;
        start_op(32'd100, 32'd7);
        repeat (8) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) seen++;
        end
        check_div("abort 81/9", 32'd81, 32'd9, 32'd9, 1'b0, 33);
        check("abort no_rdy", seen, 0);

        // Reset on E20 of a 100/7 run.
        seen = 0;
        start_op(32'd100, 32'd7);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid reset result", data_result, 32'd0);
        check("mid reset exc", {31'd0, data_exception}, 32'd0);
        check("mid reset rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) seen++;
        end
        check("mid reset no_rdy", seen, 0);
        check_div("50/5", 32'd50, 32'd5, 32'd10, 1'b0, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
